simple_proc_ext: RTL and testbench

Multi-cycle 16-bit processor core with eight general registers, a display register and a shared internal data bus. It executes one 9-bit instruction every four clock ticks. It extends the base simple processor with multiply, logical shift left and logical shift right. Register contents, the display register, the bus and the tick state are all brought out as ports for observation.

---
 rtl/simple_proc_ext.sv | 139 +++++++++++++
 tb/tb_simple_proc_ext.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/simple_proc_ext.sv
// Multi-cycle 16-bit processor (8 GPRs, display, shared bus) with MUL/SRL/SLL; one 9-bit instruction per 4 ticks.
// Result visible after the 4th edge following instruction issue; fixed cadence, no stalls or backpressure.
module simple_proc_ext (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  din,
  output logic [15:0] bus,
  output logic [15:0] R0,
  output logic [15:0] R1,
  output logic [15:0] R2,
  output logic [15:0] R3,
  output logic [15:0] R4,
  output logic [15:0] R5,
  output logic [15:0] R6,
  output logic [15:0] R7,
  output logic [15:0] display,
  output logic [3:0]  tick_FSM
);

  localparam logic [3:0] T1 = 4'b0001;
  localparam logic [3:0] T2 = 4'b0010;
  localparam logic [3:0] T3 = 4'b0100;
  localparam logic [3:0] T4 = 4'b1000;

  localparam logic [2:0] OP_DISP = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_SRL  = 3'd5;
  localparam logic [2:0] OP_SLL  = 3'd6;
  localparam logic [2:0] OP_MOVI = 3'd7;

  logic [3:0]        tick_q, tick_d;
  logic [8:0]        ir_q, ir_d;
  logic [15:0]       a_q, a_d;
  logic [15:0]       imm_q, imm_d;
  logic [15:0]       g_q, g_d;
  logic [15:0]       disp_q, disp_d;
  logic [7:0][15:0]  regs_q, regs_d;

  logic [2:0]  op;
  logic [2:0]  rx;
  logic [2:0]  ry;
  logic [15:0] alu_res;

  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  always_comb begin
    bus = 16'h0000;
    case (tick_q)
      T2:      bus = regs_q[rx];
      T3:      bus = (op == OP_ADDI || op == OP_MOVI) ? imm_q : regs_q[ry];
      T4:      bus = g_q;
      default: bus = 16'h0000;
    endcase
  end

  // Low 16 bits of the product are sign-agnostic, so an unsigned 16x16 multiply suffices.
  always_comb begin
    alu_res = a_q;
    case (op)
      OP_DISP: alu_res = a_q;
      OP_ADD:  alu_res = a_q + bus;
      OP_ADDI: alu_res = a_q + bus;
      OP_SUB:  alu_res = a_q - bus;
      OP_MUL:  alu_res = a_q * bus;
      OP_SRL:  alu_res = {1'b0, a_q[15:1]};
      OP_SLL:  alu_res = {a_q[14:0], 1'b0};
      OP_MOVI: alu_res = bus;
      default: alu_res = a_q;
    endcase
  end

  always_comb begin
    tick_d = T1;
    ir_d   = ir_q;
    a_d    = a_q;
    imm_d  = imm_q;
    g_d    = g_q;
    disp_d = disp_q;
    regs_d = regs_q;
    case (tick_q)
      T1: begin
        tick_d = T2;
        ir_d   = din;
      end
      T2: begin
        tick_d = T3;
        a_d    = bus;
        imm_d  = {{7{din[8]}}, din};
      end
      T3: begin
        tick_d = T4;
        g_d    = alu_res;
      end
      T4: begin
        tick_d = T1;
        if (op == OP_DISP) disp_d = g_q;
        else               regs_d[rx] = g_q;
      end
      default: tick_d = T1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= T1;
      ir_q   <= '0;
      a_q    <= '0;
      imm_q  <= '0;
      g_q    <= '0;
      disp_q <= '0;
      regs_q <= '0;
    end else begin
      tick_q <= tick_d;
      ir_q   <= ir_d;
      a_q    <= a_d;
      imm_q  <= imm_d;
      g_q    <= g_d;
      disp_q <= disp_d;
      regs_q <= regs_d;
    end
  end

  assign R0       = regs_q[0];
  assign R1       = regs_q[1];
  assign R2       = regs_q[2];
  assign R3       = regs_q[3];
  assign R4       = regs_q[4];
  assign R5       = regs_q[5];
  assign R6       = regs_q[6];
  assign R7       = regs_q[7];
  assign display  = disp_q;
  assign tick_FSM = tick_q;

endmodule

// File: tb/tb_simple_proc_ext.sv
// Scoreboard bench for simple_proc_ext: driver pushes reference-model state per instruction, monitor compares at T4->T1.
module tb_simple_proc_ext;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  din = 9'd0;
  logic [15:0] bus, R0, R1, R2, R3, R4, R5, R6, R7, display;
  logic [3:0]  tick_FSM;

  simple_proc_ext dut (
    .clk(clk), .rst(rst), .din(din), .bus(bus),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7),
    .display(display), .tick_FSM(tick_FSM)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][15:0] r;
    logic [15:0]      disp;
  } state_t;

  int tests = 0;
  int fails = 0;
  state_t exp_q[$];
  logic [15:0] m_r [8];
  logic [15:0] m_disp;
  logic [7:0][15:0] dut_r;

  assign dut_r = {R7, R6, R5, R4, R3, R2, R1, R0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_disp = 16'h0000;
  endfunction

  // Reference semantics in plain integer arithmetic, truncated to 16 bits.
  function automatic void model_exec(input logic [2:0] op, input logic [2:0] rx,
                                     input logic [2:0] ry, input int imm);
    longint a, b, s, res;
    a = longint'(m_r[rx]);
    b = longint'(m_r[ry]);
    s = longint'(imm);
    case (op)
      3'd1:    res = a + b;
      3'd2:    res = a + s;
      3'd3:    res = a - b;
      3'd4:    res = a * b;
      3'd5:    res = a / 2;
      3'd6:    res = a * 2;
      3'd7:    res = s;
      default: res = a;
    endcase
    res = res & 64'hFFFF;
    if (op == 3'd0) m_disp = m_r[rx];
    else            m_r[rx] = res[15:0];
  endfunction

  // Called at posedge+2 with the DUT in T1; returns at posedge+2 with the DUT back in T1.
  // abort=2..4 asserts reset at that tick's edge instead of completing.
  task automatic run_instr(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                           input int imm, input int abort);
    state_t s;
    for (int t = 1; t <= 4; t++) begin
      if (t == abort) begin
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        return;
      end
      case (t)
        1:       din = {op, rx, ry};
        2:       din = 9'(imm);
        default: din = 9'($urandom);
      endcase
      if (t == 4) begin
        model_exec(op, rx, ry, imm);
        for (int i = 0; i < 8; i++) s.r[i] = m_r[i];
        s.disp = m_disp;
        exp_q.push_back(s);
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic movi(input logic [2:0] rx, input int v);
    run_instr(3'd7, rx, 3'd0, v, 0);
  endtask

  task automatic ins(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry);
    run_instr(op, rx, ry, 0, 0);
  endtask

  // Monitor: tick sequencing, reset state, and scoreboard compare at each completed instruction.
  initial begin
    logic [3:0] prev;
    logic [3:0] exp_tick;
    logic       rst_prev;
    state_t     e;
    prev = 4'b0001;
    rst_prev = 1'b1;
    forever begin
      @(negedge clk);
      exp_tick = rst_prev ? 4'b0001 : {prev[2:0], prev[3]};
      chk("tick_FSM", {28'd0, tick_FSM}, {28'd0, exp_tick});
      if (rst_prev) begin
        for (int i = 0; i < 8; i++) chk($sformatf("reset_R%0d", i), {16'd0, dut_r[i]}, 32'd0);
        chk("reset_display", {16'd0, display}, 32'd0);
        chk("reset_bus", {16'd0, bus}, 32'd0);
      end else if (prev == 4'b1000 && tick_FSM == 4'b0001) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 8; i++) chk($sformatf("sb_R%0d", i), {16'd0, dut_r[i]}, {16'd0, e.r[i]});
          chk("sb_display", {16'd0, display}, {16'd0, e.disp});
        end
      end
      if (tick_FSM == 4'b0001) chk("bus_T1", {16'd0, bus}, 32'd0);
      prev = tick_FSM;
      rst_prev = rst;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    movi(0, 10); ins(3'd0, 0, 0);
    chk("movi_R0", {16'd0, R0}, 32'd10);
    chk("disp_R0", {16'd0, display}, 32'd10);

    movi(0, 15); ins(3'd4, 0, 0);
    chk("mul_square", {16'd0, R0}, 32'd225);

    movi(0, -10); movi(1, 20); ins(3'd4, 1, 0);
    chk("mul_neg_pos", {16'd0, R1}, 32'hFF38);
    movi(2, -30); movi(3, -33); ins(3'd4, 3, 2);
    chk("mul_neg_neg", {16'd0, R3}, 32'd990);
    movi(2, 156); movi(3, 0); ins(3'd4, 3, 2);
    chk("mul_zero", {16'd0, R3}, 32'd0);

    movi(4, 255); ins(3'd4, 4, 4);
    chk("mul_255sq", {16'd0, R4}, 32'd65025);
    ins(3'd4, 4, 4);
    chk("mul_overflow", {16'd0, R4}, 32'd64513);
    chk("mul_R3_kept", {16'd0, R3}, 32'd0);

    movi(0, -10); ins(3'd6, 0, 0);
    chk("sll_neg", {16'd0, R0}, 32'hFFEC);
    movi(0, 1);
    repeat (16) ins(3'd6, 0, 0);
    chk("sll_x16", {16'd0, R0}, 32'd0);
    movi(0, 11); ins(3'd5, 0, 0);
    chk("srl_11", {16'd0, R0}, 32'd5);
    movi(0, -123); ins(3'd5, 0, 0);
    chk("srl_neg", {16'd0, R0}, 32'd32706);

    movi(0, 11); movi(2, 103); ins(3'd6, 2, 2); ins(3'd5, 0, 0);
    ins(3'd4, 0, 2); ins(3'd0, 0, 0);
    chk("combined_disp", {16'd0, display}, 32'd1030);

    movi(5, 77);
    run_instr(3'd7, 6, 0, 99, 3);
    chk("abort_R5", {16'd0, R5}, 32'd0);
    chk("abort_R6", {16'd0, R6}, 32'd0);
    chk("abort_display", {16'd0, display}, 32'd0);
    chk("abort_tick", {28'd0, tick_FSM}, 32'd1);

    for (int n = 0; n < 300; n++) begin
      logic [2:0] op, rx, ry;
      int imm, ab;
      op  = 3'($urandom_range(0, 7));
      rx  = 3'($urandom_range(0, 7));
      ry  = 3'($urandom_range(0, 7));
      imm = int'($urandom_range(0, 511)) - 256;
      ab  = ($urandom_range(0, 39) == 0) ? int'($urandom_range(2, 4)) : 0;
      run_instr(op, rx, ry, imm, ab);
    end

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
